// File: rtl/arm_defs.sv
// Shared ARM decode constants: ALU commands, opcodes, condition codes, instruction modes.
// Pure definitions; no timing or flow-control behaviour.
package arm_defs;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// 15 x DW register file, 1 write + 2 combinational read ports with same-cycle write bypass.
// Reads are 0-cycle; index 15 returns pc; writes to index 15 are dropped; no backpressure.
module reg_file #(
  parameter int DW          = 32,
  parameter int RF_INIT_IDX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [3:0]    raddr1,
  input  logic [3:0]    raddr2,
  input  logic [DW-1:0] pc,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [15];
  logic          wr_ok;

  assign wr_ok = we && (waddr != 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (RF_INIT_IDX != 0) ? DW'(i) : '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // R15 is the PC and never lives in the array.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == 4'd15)                 rdata1 = pc;
    else if (wr_ok && waddr == raddr1)   rdata1 = wdata;
    else                                 rdata1 = regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 == 4'd15)                 rdata2 = pc;
    else if (wr_ok && waddr == raddr2)   rdata2 = wdata;
    else                                 rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// ARM ID stage: decode, condition check, operand read and bubble insertion feeding ID/EXE.
// Fully combinational except the register file; hazard or failed condition zeroes control.
module id_stage
  import arm_defs::*;
#(
  parameter int DW          = 32,
  parameter int RF_INIT_IDX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   Instruction,
  input  logic [DW-1:0] PC_IN,
  input  logic [3:0]    Status,
  input  logic          hazard,
  input  logic          WB_WB_EN,
  input  logic [3:0]    WB_Dest,
  input  logic [DW-1:0] WB_Value,
  output logic          WB_EN,
  output logic          MEM_R_EN,
  output logic          MEM_W_EN,
  output logic          B,
  output logic          S,
  output logic [3:0]    EXE_CMD,
  output logic [DW-1:0] PC,
  output logic [DW-1:0] Val_Rn,
  output logic [DW-1:0] Val_Rm,
  output logic          imm,
  output logic [11:0]   Shift_operand,
  output logic [23:0]   Signed_imm_24,
  output logic [3:0]    Dest,
  output logic [3:0]    Src1,
  output logic [3:0]    Src2,
  output logic          Two_src
);

  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] op;
  logic       s_bit;
  ctrl_t      dec;
  ctrl_t      ctrl;

  assign cond  = Instruction[31:28];
  assign mode  = Instruction[27:26];
  assign op    = Instruction[24:21];
  assign s_bit = Instruction[20];

  always_comb begin
    dec = '0;
    case (mode)
      MODE_DP: begin
        dec.wb_en = 1'b1;
        dec.s     = s_bit;
        case (op)
          OP_MOV:  dec.exe_cmd = CMD_MOV;
          OP_MVN:  dec.exe_cmd = CMD_MVN;
          OP_ADD:  dec.exe_cmd = CMD_ADD;
          OP_ADC:  dec.exe_cmd = CMD_ADC;
          OP_SUB:  dec.exe_cmd = CMD_SUB;
          OP_SBC:  dec.exe_cmd = CMD_SBC;
          OP_AND:  dec.exe_cmd = CMD_AND;
          OP_ORR:  dec.exe_cmd = CMD_ORR;
          OP_EOR:  dec.exe_cmd = CMD_EOR;
          OP_CMP:  begin dec.exe_cmd = CMD_SUB; dec.wb_en = 1'b0; end
          OP_TST:  begin dec.exe_cmd = CMD_AND; dec.wb_en = 1'b0; end
          default: dec = '0;
        endcase
      end
      MODE_MEM: begin
        dec.exe_cmd  = CMD_ADD;
        dec.wb_en    = s_bit;
        dec.mem_r_en = s_bit;
        dec.mem_w_en = ~s_bit;
      end
      MODE_BR: dec.b = 1'b1;
      default: dec = '0;
    endcase
  end

  assign ctrl = (hazard || !cond_pass(cond, Status)) ? '0 : dec;

  assign WB_EN    = ctrl.wb_en;
  assign MEM_R_EN = ctrl.mem_r_en;
  assign MEM_W_EN = ctrl.mem_w_en;
  assign B        = ctrl.b;
  assign S        = ctrl.s;
  assign EXE_CMD  = ctrl.exe_cmd;

  // Operand routing uses the pre-bubble decode so the hazard unit sees stable indices.
  assign imm           = Instruction[25];
  assign Shift_operand = Instruction[11:0];
  assign Signed_imm_24 = Instruction[23:0];
  assign Dest          = Instruction[15:12];
  assign Src1          = Instruction[19:16];
  assign Src2          = dec.mem_w_en ? Instruction[15:12] : Instruction[3:0];
  assign Two_src       = ~Instruction[25] | dec.mem_w_en;
  assign PC            = PC_IN;

  reg_file #(.DW(DW), .RF_INIT_IDX(RF_INIT_IDX)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (WB_WB_EN),
    .waddr  (WB_Dest),
    .wdata  (WB_Value),
    .raddr1 (Src1),
    .raddr2 (Src2),
    .pc     (PC_IN),
    .rdata1 (Val_Rn),
    .rdata2 (Val_Rm)
  );

endmodule
